// File: rtl/data_mem_responder_pkg.sv
// data_mem_responder_pkg: shared FSM state type and parameter defaults for the data memory responder
package data_mem_responder_pkg;
  typedef enum logic [1:0] {S_IDLE, S_WAIT, S_DONE} state_t;
  localparam int DEF_DEPTH   = 1024;
  localparam int DEF_LATENCY = 2;
endpackage

// File: rtl/data_mem_array.sv
// data_mem_array: single-port DEPTH x 32 storage with synchronous write and registered read, no reset
module data_mem_array
  import data_mem_responder_pkg::*;
#(
  parameter int DEPTH = DEF_DEPTH,
  parameter int AW    = $clog2(DEF_DEPTH)
) (
  input  logic          clk,
  input  logic          i_we,
  input  logic [AW-1:0] i_addr,
  input  logic [31:0]   i_wdata,
  output logic [31:0]   o_rdata
);
  logic [31:0] r_mem [DEPTH];
  // Read every cycle so the word at the live address is ready by the completing edge
  always_ff @(posedge clk) begin
    if (i_we) r_mem[i_addr] <= i_wdata;
    o_rdata <= r_mem[i_addr];
  end
endmodule

// File: rtl/data_mem_responder.sv
// data_mem_responder: latency-programmable load/store responder that aborts and restarts on any input change
module data_mem_responder
  import data_mem_responder_pkg::*;
#(
  parameter int          DEPTH     = DEF_DEPTH,
  parameter int          LATENCY   = DEF_LATENCY,
  parameter logic [31:0] BASE_ADDR = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [31:0] d_address,
  input  logic [31:0] d_data_write,
  input  logic        d_write_enable,
  output logic [31:0] d_data_read,
  output logic        d_data_valid,
  output logic        d_error
);
  localparam int AW = DEPTH > 1 ? $clog2(DEPTH) : 1;
  localparam logic [3:0] RELOAD = 4'(LATENCY - 1);
  state_t      r_state, w_next;
  logic [3:0]  r_cnt, w_cnt;
  logic [31:0] r_addr, r_wdata, r_data, w_data, w_rdata, w_index;
  logic        r_we, r_valid, r_err, w_valid, w_err_n;
  logic        w_same, w_relatch, w_fire, w_err, w_mem_we;
  assign w_same    = d_address == r_addr && d_data_write == r_wdata && d_write_enable == r_we;
  assign w_relatch = r_state == S_IDLE || !w_same;
  assign w_fire    = r_state == S_WAIT && w_same && r_cnt == 4'd0;
  assign w_index   = (d_address - BASE_ADDR) >> 2;
  assign w_err     = d_address[1:0] != 2'b00 || w_index >= 32'(DEPTH);
  assign w_mem_we  = w_fire && d_write_enable && !w_err;
  data_mem_array #(.DEPTH(DEPTH), .AW(AW)) u_array (
    .clk     (clk),
    .i_we    (w_mem_we),
    .i_addr  (w_index[AW-1:0]),
    .i_wdata (d_data_write),
    .o_rdata (w_rdata)
  );
  // State register; reset abandons any pending access before it can write
  always_ff @(posedge clk or posedge reset) begin
    if (reset) r_state <= S_IDLE;
    else       r_state <= w_next;
  end
  // Next state: any input change restarts the wait, a zero count completes it
  always_comb begin
    w_next = r_state;
    w_next = w_relatch ? S_WAIT : w_fire ? S_DONE : r_state;
  end
  // Next counter and response values; the response is captured only on the completing edge
  always_comb begin
    w_cnt   = r_cnt;
    w_valid = r_valid;
    w_err_n = r_err;
    w_data  = r_data;
    w_cnt   = w_relatch ? RELOAD : (r_state == S_WAIT && r_cnt != 4'd0) ? r_cnt - 4'd1 : r_cnt;
    w_valid = w_relatch ? 1'b0 : w_fire ? 1'b1 : r_valid;
    w_err_n = w_relatch ? 1'b0 : w_fire ? w_err : r_err;
    w_data  = w_fire ? (w_err ? 32'h0 : d_write_enable ? d_data_write : w_rdata) : r_data;
  end
  // Request registers track the live inputs, which equal the latched copy whenever no relatch occurs
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_cnt   <= 4'd0;
      r_addr  <= 32'h0;
      r_wdata <= 32'h0;
      r_we    <= 1'b0;
      r_data  <= 32'h0;
      r_valid <= 1'b0;
      r_err   <= 1'b0;
    end else begin
      r_cnt   <= w_cnt;
      r_addr  <= d_address;
      r_wdata <= d_data_write;
      r_we    <= d_write_enable;
      r_data  <= w_data;
      r_valid <= w_valid;
      r_err   <= w_err_n;
    end
  end
  assign d_data_read  = r_data;
  assign d_data_valid = r_valid;
  assign d_error      = r_err;
endmodule

// File: tb/tb_data_mem_responder.sv
// tb_data_mem_responder: directed plus randomized checks against a word-array reference model
module tb_data_mem_responder;
  localparam int DEPTH = 1024;
  localparam int LAT = 2;
  localparam logic [31:0] BASE = 32'h0;
  logic clk = 1'b0, reset = 1'b1;
  logic [31:0] d_address = 32'h0, d_data_write = 32'h0, d_data_read;
  logic d_write_enable = 1'b0, d_data_valid, d_error;
  int n_assert = 0, n_fail = 0, wr_count = 0, exp_writes = 0;
  logic [31:0] model [DEPTH];

  data_mem_responder #(.DEPTH(DEPTH), .LATENCY(LAT), .BASE_ADDR(BASE)) dut (
    .clk(clk), .reset(reset), .d_address(d_address), .d_data_write(d_data_write),
    .d_write_enable(d_write_enable), .d_data_read(d_data_read),
    .d_data_valid(d_data_valid), .d_error(d_error)
  );

  always #5 clk = ~clk;

  always @(posedge clk) if (dut.w_mem_we) wr_count <= wr_count + 1;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
    n_assert++;
    assert (obs === exp_v) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp_v);
    end
  endtask

  function automatic logic bad(input logic [31:0] a);
    logic [31:0] idx;
    idx = (a - BASE) / 4;
    return (a % 4) != 0 || idx >= DEPTH;
  endfunction

  // Drive a request (caller is at a negedge), check the latency window, then the held response
  task automatic run_access(input logic [31:0] a, input logic [31:0] d, input logic we, input int hold);
    logic e;
    logic [31:0] idx, exp_d;
    if (a == d_address && d == d_data_write && we == d_write_enable) d = d ^ 32'h1;
    d_address = a; d_data_write = d; d_write_enable = we;
    for (int k = 0; k < LAT; k++) begin
      @(negedge clk);
      chk("valid_low_during_wait", 32'(d_data_valid), 32'h0);
    end
    @(negedge clk);
    e = bad(a);
    idx = (a - BASE) / 4;
    exp_d = e ? 32'h0 : we ? d : model[idx];
    if (we && !e) begin
      model[idx] = d;
      exp_writes++;
    end
    chk("valid_at_latency", 32'(d_data_valid), 32'h1);
    chk("error_flag", 32'(d_error), 32'(e));
    chk("read_data", d_data_read, exp_d);
    for (int k = 0; k < hold; k++) begin
      @(negedge clk);
      chk("valid_hold", 32'(d_data_valid), 32'h1);
      chk("data_hold", d_data_read, exp_d);
    end
  endtask

  // Start a request and replace it after a single edge
  task automatic aborted(input logic [31:0] a1, input logic [31:0] d1, input logic we1,
                         input logic [31:0] a2, input logic [31:0] d2, input logic we2);
    if (a1 == d_address && d1 == d_data_write && we1 == d_write_enable) d1 = d1 ^ 32'h2;
    d_address = a1; d_data_write = d1; d_write_enable = we1;
    @(negedge clk);
    chk("valid_low_after_latch", 32'(d_data_valid), 32'h0);
    run_access(a2, d2, we2, 0);
  endtask

  function automatic logic [31:0] rand_addr();
    int kind;
    kind = $urandom_range(0, 9);
    if (kind == 0) return (32'($urandom_range(0, 15)) * 4) | 32'($urandom_range(1, 3));
    if (kind == 1) return ($urandom() | 32'h0000_1000) & 32'hFFFF_FFFC;
    return 32'($urandom_range(0, 15)) * 4;
  endfunction

  initial begin
    int w0;
    logic [31:0] ra, rd;
    logic rw;
    repeat (3) @(negedge clk);
    chk("reset_read", d_data_read, 32'h0);
    chk("reset_valid", 32'(d_data_valid), 32'h0);
    chk("reset_error", 32'(d_error), 32'h0);
    reset = 1'b0;
    for (int i = 0; i < 16; i++) run_access(32'(i) * 4, $urandom(), 1'b1, 0);
    // Store held, then readback
    run_access(32'h10, 32'hDEAD_BEEF, 1'b1, 3);
    run_access(32'h10, 32'h0, 1'b0, 1);
    chk("load_deadbeef", d_data_read, 32'hDEAD_BEEF);
    // Address change one edge after latch
    aborted(32'h20, 32'h0, 1'b0, 32'h24, 32'h0, 1'b0);
    // Aborted store has no side effect
    w0 = wr_count;
    aborted(32'h08, 32'h1234_5678, 1'b1, 32'h0C, 32'h0, 1'b0);
    chk("abort_no_write", 32'(wr_count - w0), 32'h0);
    run_access(32'h08, 32'h0, 1'b0, 0);
    // Error cases
    run_access(32'h1002, 32'h0, 1'b0, 0);
    chk("misaligned_data_zero", d_data_read, 32'h0);
    w0 = wr_count;
    run_access(32'h1000, 32'hFFFF_FFFF, 1'b1, 0);
    chk("oob_store_dropped", 32'(wr_count - w0), 32'h0);
    run_access(32'h0, 32'h0, 1'b0, 0);
    // Reset during a store's wait
    w0 = wr_count;
    d_address = 32'h10; d_data_write = 32'hCAFE_F00D; d_write_enable = 1'b1;
    @(negedge clk);
    #2 reset = 1'b1;
    #1;
    chk("reset_mid_read", d_data_read, 32'h0);
    chk("reset_mid_valid", 32'(d_data_valid), 32'h0);
    chk("reset_mid_error", 32'(d_error), 32'h0);
    @(negedge clk);
    reset = 1'b0;
    run_access(32'h10, 32'h0, 1'b0, 0);
    chk("reset_no_write", 32'(wr_count - w0), 32'h0);
    // Store held in completion for ten cycles writes exactly once
    w0 = wr_count;
    run_access(32'h14, 32'h5A5A_A5A5, 1'b1, 10);
    chk("single_write", 32'(wr_count - w0), 32'h1);
    // Randomized traffic
    for (int i = 0; i < 40; i++) begin
      ra = rand_addr(); rd = $urandom(); rw = 1'($urandom_range(0, 1));
      if ($urandom_range(0, 4) == 0) aborted(rand_addr(), $urandom(), 1'($urandom_range(0, 1)), ra, rd, rw);
      else run_access(ra, rd, rw, $urandom_range(0, 2));
    end
    @(negedge clk);
    chk("total_writes", 32'(wr_count), 32'(exp_writes));
    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end
endmodule

// File: doc/data_mem_responder.md
DATA_MEM_RESPONDER -- requirements
Module: data_mem_responder

Interface
REQ-001 Parameter DEPTH, default 1024, SHALL be the number of 32-bit words stored.
REQ-002 Parameter LATENCY, default 2, legal range 1..15, SHALL be the number of clock edges from access latch to d_data_valid assertion.
REQ-003 Parameter BASE_ADDR, default 32'h0000_0000, SHALL be the byte address of word 0.
REQ-004 One clock; reset is asynchronous and active-high.
REQ-005 Port clk, input, 1 bit: the single clock; all state updates on its rising edge.
REQ-006 Port reset, input, 1 bit: asynchronous, active-high reset.
REQ-007 Port d_address, input, 32 bits: byte address from the core.
REQ-008 Port d_data_write, input, 32 bits: store data.
REQ-009 Port d_write_enable, input, 1 bit: 1 = store, 0 = load.
REQ-010 Port d_data_read, output, 32 bits: registered load data.
REQ-011 Port d_data_valid, output, 1 bit: access completed, with d_data_read and d_error meaningful.
REQ-012 Port d_error, output, 1 bit: the completed access was misaligned or out of range.

Function
REQ-013 The FSM SHALL have states IDLE, WAIT and DONE, with a 4-bit countdown counter.
REQ-014 IDLE: on the first edge after reset release, latch d_address, d_data_write and d_write_enable into request registers, load counter = LATENCY-1, and go to WAIT.
REQ-015 WAIT, live inputs equal to the latched request, counter > 0: decrement the counter.
REQ-016 WAIT, live inputs equal to the latched request, counter == 0: go to DONE, perform the access, and set d_data_valid=1 on the same edge.
REQ-017 WAIT or DONE, any of the three inputs differs from the latched request: relatch the inputs, reload counter = LATENCY-1, go to WAIT, and set d_data_valid=0 on the same edge; an aborted access SHALL have no side effect.
REQ-018 In DONE with unchanged inputs, d_data_valid and d_data_read SHALL hold and no further write SHALL occur; each write SHALL commit exactly once.
REQ-019 Timing: for inputs stable from latch edge E0, d_data_valid SHALL be high after edge E0+LATENCY.
REQ-020 Word index SHALL be (d_address - BASE_ADDR) >> 2, computed modulo 2^32.
REQ-021 An access is in range when the index is < DEPTH.
REQ-022 An access is misaligned when d_address[1:0] != 0.
REQ-023 A valid load SHALL set d_data_read to mem[index].
REQ-024 A valid store SHALL write mem[index] and set d_data_read to the store data.
REQ-025 A misaligned or out-of-range load SHALL return 0 with d_error=1.
REQ-026 A misaligned or out-of-range store SHALL be dropped, return 0, and set d_error=1.
REQ-027 d_error SHALL be registered alongside d_data_valid and cleared whenever d_data_valid falls.
REQ-028 Outside valid cycles, d_data_read SHALL hold its last value.

Reset
REQ-029 While reset is high, outputs SHALL be d_data_read=0, d_data_valid=0, d_error=0; state SHALL be IDLE, counter 0, request registers 0.
REQ-030 Reset mid-WAIT SHALL abandon the pending access with no memory write; memory contents SHALL NOT be cleared by reset.

Structure
REQ-031 A shared package SHALL hold the state enum type and the default values of DEPTH and LATENCY.
REQ-032 Storage SHALL be one sub-module, data_mem_array: single-port, synchronous write and read, DEPTH x 32, no reset.

Verification (LATENCY=2, BASE_ADDR=0, DEPTH=1024)
REQ-033 Store 32'hDEAD_BEEF to 0x10, held 3 cycles, then load 0x10 -> valid 2 edges after each latch, load returns 32'hDEAD_BEEF, d_error=0.
REQ-034 Load 0x20, then change the address to 0x24 one edge after latch -> no valid for 0x20, valid 2 edges after the 0x24 latch.
REQ-035 Store 32'h1234_5678 to 0x08 aborted after 1 edge by a change to a load of 0x0C -> mem[2] unchanged.
REQ-036 Load 0x1002 -> d_error=1, data 0; store 32'hFFFF_FFFF to 0x1000 (index 1024) -> d_error=1, then a load of 0x0 is unchanged.
REQ-037 Assert reset during WAIT of a store -> outputs 0 immediately; after release, a load of the same address returns the old data.
REQ-038 A store held in DONE for 10 cycles SHALL produce exactly one array write, checked by a write-count assertion.
